sha256_compress_ctrl: RTL and testbench

- Sequences the SHA-256 compression datapath for one 512-bit block: load, 64 rounds at one round per cycle, then the final feed-forward add.
- Owns the working registers a..h, the 16-word message-schedule window, the round counter and the hash state H0..H7.
- Sits between the message padder (upstream, valid/ready) and the digest consumer (downstream, valid/ready).
- Σ/σ functions are built from the team's fixed rotate-right modules.

---
 rtl/sha256_pkg.sv | 38 +++
 rtl/sha256_round.sv | 61 ++++++
 rtl/sha256_compress_ctrl.sv | 133 +++++++++++++
 tb/tb_sha256_compress_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// SHA-256 shared definitions: word type, round constants K, initial hash value IV
// and the compression controller state encoding.
package sha256_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam word_t K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam word_t IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_round.sv
// Fixed rotate-right primitive and one combinational SHA-256 compression round
// (Sigma0/Sigma1, Ch, Maj, T1/T2 and the a..h shuffle).
module sha256_rotr
  import sha256_pkg::*;
#(
  parameter int unsigned N = 1
) (
  input  word_t i_x,
  output word_t o_y
);
  assign o_y = {i_x[N-1:0], i_x[31:N]};
endmodule

module sha256_round
  import sha256_pkg::*;
(
  input  word_t i_a,
  input  word_t i_b,
  input  word_t i_c,
  input  word_t i_d,
  input  word_t i_e,
  input  word_t i_f,
  input  word_t i_g,
  input  word_t i_h,
  input  word_t i_k,
  input  word_t i_w,
  output word_t o_a,
  output word_t o_b,
  output word_t o_c,
  output word_t o_d,
  output word_t o_e,
  output word_t o_f,
  output word_t o_g,
  output word_t o_h
);
  word_t w_a2, w_a13, w_a22, w_e6, w_e11, w_e25;
  word_t w_bsig0, w_bsig1, w_ch, w_maj, w_t1, w_t2;

  sha256_rotr #(.N(2))  u_rot_a2  (.i_x(i_a), .o_y(w_a2));
  sha256_rotr #(.N(13)) u_rot_a13 (.i_x(i_a), .o_y(w_a13));
  sha256_rotr #(.N(22)) u_rot_a22 (.i_x(i_a), .o_y(w_a22));
  sha256_rotr #(.N(6))  u_rot_e6  (.i_x(i_e), .o_y(w_e6));
  sha256_rotr #(.N(11)) u_rot_e11 (.i_x(i_e), .o_y(w_e11));
  sha256_rotr #(.N(25)) u_rot_e25 (.i_x(i_e), .o_y(w_e25));

  assign w_bsig0 = w_a2 ^ w_a13 ^ w_a22;
  assign w_bsig1 = w_e6 ^ w_e11 ^ w_e25;
  assign w_ch    = (i_e & i_f) ^ (~i_e & i_g);
  assign w_maj   = (i_a & i_b) ^ (i_a & i_c) ^ (i_b & i_c);
  assign w_t1    = i_h + w_bsig1 + w_ch + i_k + i_w;
  assign w_t2    = w_bsig0 + w_maj;

  assign o_a = w_t1 + w_t2;
  assign o_b = i_a;
  assign o_c = i_b;
  assign o_d = i_c;
  assign o_e = i_d + w_t1;
  assign o_f = i_e;
  assign o_g = i_f;
  assign o_h = i_g;
endmodule

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 single-block compression controller, one round per clock.
// Define SHA256_CHAIN_EN to add blk_first and keep H across blocks (multi-block messages).
//   state | meaning
//   IDLE  | waiting for a block, blk_ready high
//   ROUND | one compression round per cycle, schedule window shifting
//   FINAL | feed-forward add of a..h into H
//   DONE  | digest presented until dig_ready
module sha256_compress_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
`ifdef SHA256_CHAIN_EN
  input  logic         blk_first,
`endif
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic [255:0] dig_data,
  output logic         busy
);
  if (ROUNDS != 64) begin : g_rounds_check
    $error("sha256_compress_ctrl: ROUNDS must be 64");
  end

  state_t     r_state, w_state_nxt;
  logic [6:0] r_round;
  word_t      r_v   [0:7];
  word_t      r_h   [0:7];
  word_t      r_win [0:15];
  word_t      w_nxt [0:7];
  word_t      w_s0_7, w_s0_18, w_s1_17, w_s1_19;
  word_t      w_ssig0, w_ssig1, w_wt;
  logic       w_accept, w_load_iv;

`ifdef SHA256_CHAIN_EN
  assign w_load_iv = blk_first;
`else
  assign w_load_iv = 1'b1;
`endif

  // Window holds W[t-16..t-1]; index 1 is W[t-15], 9 is W[t-7], 14 is W[t-2].
  sha256_rotr #(.N(7))  u_rot_s0_7  (.i_x(r_win[1]),  .o_y(w_s0_7));
  sha256_rotr #(.N(18)) u_rot_s0_18 (.i_x(r_win[1]),  .o_y(w_s0_18));
  sha256_rotr #(.N(17)) u_rot_s1_17 (.i_x(r_win[14]), .o_y(w_s1_17));
  sha256_rotr #(.N(19)) u_rot_s1_19 (.i_x(r_win[14]), .o_y(w_s1_19));

  assign w_ssig0 = w_s0_7 ^ w_s0_18 ^ (r_win[1] >> 3);
  assign w_ssig1 = w_s1_17 ^ w_s1_19 ^ (r_win[14] >> 10);
  assign w_wt    = (r_round < 7'd16) ? r_win[0]
                                     : w_ssig1 + r_win[9] + w_ssig0 + r_win[0];

  sha256_round u_round (
    .i_a(r_v[0]), .i_b(r_v[1]), .i_c(r_v[2]), .i_d(r_v[3]),
    .i_e(r_v[4]), .i_f(r_v[5]), .i_g(r_v[6]), .i_h(r_v[7]),
    .i_k(K[r_round[5:0]]), .i_w(w_wt),
    .o_a(w_nxt[0]), .o_b(w_nxt[1]), .o_c(w_nxt[2]), .o_d(w_nxt[3]),
    .o_e(w_nxt[4]), .o_f(w_nxt[5]), .o_g(w_nxt[6]), .o_h(w_nxt[7])
  );

  assign w_accept = (r_state == IDLE) && blk_valid;

  always_comb begin
    w_state_nxt = r_state;
    blk_ready   = 1'b0;
    dig_valid   = 1'b0;
    busy        = 1'b0;
    case (r_state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) w_state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (r_round == 7'(ROUNDS - 1)) w_state_nxt = FINAL;
      end
      FINAL: begin
        busy        = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: begin
        dig_valid = 1'b1;
        if (dig_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_round <= '0;
      for (int i = 0; i < 8; i++) begin
        r_v[i] <= '0;
        r_h[i] <= IV[i];
      end
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: if (w_accept) begin
          r_round <= '0;
          for (int i = 0; i < 16; i++) r_win[i] <= blk_data[511-32*i -: 32];
          for (int i = 0; i < 8; i++) begin
            if (w_load_iv) begin
              r_v[i] <= IV[i];
              r_h[i] <= IV[i];
            end else begin
              r_v[i] <= r_h[i];
            end
          end
        end
        ROUND: begin
          r_round <= r_round + 7'd1;
          for (int i = 0; i < 8; i++) r_v[i] <= w_nxt[i];
          for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
          r_win[15] <= w_wt;
        end
        FINAL: for (int i = 0; i < 8; i++) r_h[i] <= r_h[i] + r_v[i];
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < 8; g++) begin : g_dig
    assign dig_data[255-32*g -: 32] = r_h[g];
  end

endmodule

// File: tb/tb_sha256_compress_ctrl.sv
// Self-checking bench for sha256_compress_ctrl: known vectors, random blocks against a
// FIPS 180-4 reference model, DONE stall, mid-round reset and ignored blk_valid pulses.
module tb_sha256_compress_ctrl;

`ifdef SHA256_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  localparam logic [255:0] IV_VEC =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIG =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'h0};

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid, blk_ready, blk_first;
  logic [511:0] blk_data;
  logic         dig_valid, dig_ready, busy;
  logic [255:0] dig_data;

  int           n_checks = 0;
  int           n_fail   = 0;
  logic [255:0] tb_h;
  logic [255:0] tb_exp;

  sha256_compress_ctrl #(.ROUNDS(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .blk_data (blk_data),
`ifdef SHA256_CHAIN_EN
    .blk_first(blk_first),
`endif
    .dig_valid(dig_valid),
    .dig_ready(dig_ready),
    .dig_data (dig_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hv [8];
    logic [31:0] s0, s1, t1, t2, ch, maj;
    logic [255:0] res;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = s1 + w[i-7] + s0 + w[i-16];
    end
    for (int i = 0; i < 8; i++) begin
      hv[i] = hin[255-32*i -: 32];
      v[i]  = hv[i];
    end
    for (int t = 0; t < 64; t++) begin
      ch  = (v[4] & v[5]) ^ (~v[4] & v[6]);
      maj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1  = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ch + KT[t] + w[t];
      t2  = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + maj;
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hv[i] + v[i];
    return res;
  endfunction

  // Offers a block, waits for it to complete; returns with the DUT in DONE.
  task automatic send_block(input logic [511:0] d, input logic first, input logic [255:0] known,
                            input bit has_known, input bit pulse);
    int n;
    int lat;
    logic [255:0] base;
    blk_data  = d;
    blk_first = first;
    blk_valid = 1'b1;
    n = 0;
    while (!blk_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    check_eq("accept_ready", blk_ready, 1'b1);
    base   = (blk_first || !CHAIN) ? IV_VEC : tb_h;
    tb_exp = has_known ? known : ref_compress(base, d);
    @(posedge clk); #1;
    blk_valid = 1'b0;
    check_eq("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!dig_valid && lat < 100) begin
      if (pulse && lat < 60) begin
        check_eq("ready_low_in_round", blk_ready, 1'b0);
        blk_valid = 1'($urandom_range(0, 1));
        dig_ready = 1'($urandom_range(0, 1));
        blk_data  = {16{$urandom()}};
      end else begin
        blk_valid = 1'b0;
        dig_ready = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    blk_valid = 1'b0;
    dig_ready = 1'b0;
    check_eq("latency", 256'(lat), 256'(65));
    check_eq("digest", dig_data, tb_exp);
    check_eq("busy_in_done", busy, 1'b0);
    tb_h = tb_exp;
  endtask

  task automatic take_digest();
    dig_ready = 1'b1;
    @(posedge clk); #1;
    dig_ready = 1'b0;
    check_eq("dig_valid_drop", dig_valid, 1'b0);
    check_eq("ready_after_hs", blk_ready, 1'b1);
  endtask

  initial begin
    logic [511:0] rblk;
    rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b1; blk_data = '0; dig_ready = 1'b0;
    tb_h = IV_VEC; tb_exp = IV_VEC;
    #12;
    check_eq("rst_blk_ready", blk_ready, 1'b1);
    check_eq("rst_dig_valid", dig_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_dig_data", dig_data, IV_VEC);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    send_block(ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b0);
    take_digest();
    send_block(EMPTY_BLK, 1'b1, EMPTY_DIG, 1'b1, 1'b0);
    take_digest();

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 16; i++) rblk[511-32*i -: 32] = $urandom();
      send_block(rblk, 1'b1, '0, 1'b0, k[0]);
      take_digest();
    end

    // blk_valid pulses and stray dig_ready during ROUND must not disturb "abc"
    send_block(ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b1);
    take_digest();

`ifdef SHA256_CHAIN_EN
    send_block({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000},
               1'b1, '0, 1'b0, 1'b0);
    take_digest();
    send_block({448'h0, 64'h1c0}, 1'b0,
               256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1, 1'b1, 1'b0);
    take_digest();
`endif

    // Stall in DONE with a second block already offered
    send_block(EMPTY_BLK, 1'b1, EMPTY_DIG, 1'b1, 1'b0);
    blk_data  = ABC_BLK;
    blk_first = 1'b1;
    blk_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check_eq("stall_dig_valid", dig_valid, 1'b1);
      check_eq("stall_dig_data", dig_data, EMPTY_DIG);
      check_eq("stall_blk_ready", blk_ready, 1'b0);
    end
    take_digest();
    send_block(ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b0);
    take_digest();

    // Reset during round 30
    blk_data = ABC_BLK; blk_first = 1'b1; blk_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_accept_ready", blk_ready, 1'b0);
    blk_valid = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
    end
    check_eq("mid_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 1'b0);
    check_eq("arst_blk_ready", blk_ready, 1'b1);
    check_eq("arst_dig_valid", dig_valid, 1'b0);
    check_eq("arst_dig_data", dig_data, IV_VEC);
    @(negedge clk); rst = 1'b0;
    tb_h = IV_VEC;
    @(posedge clk); #1;
    send_block(ABC_BLK, 1'b1, ABC_DIG, 1'b1, 1'b0);
    take_digest();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
